// File: rtl/stream_fifo.sv
// Valid/ready synchronous FIFO with explicit pointer wrap, so any DEPTH >= 2 works.
// Handshake outputs come only from registered occupancy, so there is no ready/valid combinational path.
module stream_fifo #(
  parameter int WIDTH           = 32,
  parameter int DEPTH           = 16,
  parameter int ALMOST_FULL_LVL = DEPTH - 1,
  localparam int CW             = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] down_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= CW'(ALMOST_FULL_LVL));
  assign count       = count_q;
  assign up_ready    = !full;
  assign down_valid  = !empty;
  assign down_data   = mem_q[rd_ptr_q];

  assign push = up_valid && up_ready;
  assign pop  = down_valid && down_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; down_data is only meaningful with down_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= up_data;
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo (WIDTH=8, DEPTH=5, ALMOST_FULL_LVL=4): directed scenarios
// plus random traffic, all outputs compared against a queue-based reference.
module tb_stream_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int AFL   = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             up_valid;
  logic             up_ready;
  logic [WIDTH-1:0] up_data;
  logic             down_valid;
  logic             down_ready;
  logic [WIDTH-1:0] down_data;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             almost_full;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] model_q[$];

  stream_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .ALMOST_FULL_LVL(AFL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .up_valid(up_valid),
    .up_ready(up_ready),
    .up_data(up_data),
    .down_valid(down_valid),
    .down_ready(down_ready),
    .down_data(down_data),
    .count(count),
    .full(full),
    .empty(empty),
    .almost_full(almost_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = model_q.size();
    chk({tag, "_count"}, 32'(count), 32'(sz));
    chk({tag, "_empty"}, 32'(empty), 32'(sz == 0));
    chk({tag, "_full"}, 32'(full), 32'(sz == DEPTH));
    chk({tag, "_afull"}, 32'(almost_full), 32'(sz >= AFL));
    chk({tag, "_upready"}, 32'(up_ready), 32'(sz != DEPTH));
    chk({tag, "_dvalid"}, 32'(down_valid), 32'(sz != 0));
    if (sz != 0) chk({tag, "_ddata"}, 32'(down_data), 32'(model_q[0]));
  endtask

  // Drive one cycle; outputs are checked mid-cycle, model advances at the edge.
  task automatic step(input string tag, input logic uv, input logic [WIDTH-1:0] ud, input logic dr);
    bit do_push, do_pop;
    @(negedge clk);
    up_valid   = uv;
    up_data    = ud;
    down_ready = dr;
    #1;
    check_model(tag);
    do_push = uv && (model_q.size() < DEPTH);
    do_pop  = dr && (model_q.size() > 0);
    @(posedge clk);
    if (do_pop)  void'(model_q.pop_front());
    if (do_push) model_q.push_back(ud);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (model_q.size() == 0) break;
      step(tag, 1'b0, '0, 1'b1);
    end
    #1;
    chk({tag, "_drained"}, 32'(empty), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    up_valid   = 1'b0;
    up_data    = '0;
    down_ready = 1'b0;
    #12;
    check_model("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: three pushes then in-order drain
    step("s1_push", 1'b1, 8'h11, 1'b0);
    step("s1_push", 1'b1, 8'h22, 1'b0);
    step("s1_push", 1'b1, 8'h33, 1'b0);
    #1;
    chk("s1_cnt3", 32'(count), 32'd3);
    chk("s1_head", 32'(down_data), 32'h11);
    step("s1_pop", 1'b0, '0, 1'b1);
    step("s1_pop", 1'b0, '0, 1'b1);
    step("s1_pop", 1'b0, '0, 1'b1);
    #1;
    chk("s1_empty", 32'(empty), 32'd1);
    chk("s1_cnt0", 32'(count), 32'd0);

    // 2: fill to full, rejected offer, drain
    for (int i = 1; i <= DEPTH; i++) begin
      step("s2_fill", 1'b1, 8'(i), 1'b0);
      #1;
      chk("s2_afull", 32'(almost_full), 32'(i >= 4));
    end
    chk("s2_full", 32'(full), 32'd1);
    chk("s2_upready", 32'(up_ready), 32'd0);
    step("s2_offer", 1'b1, 8'h66, 1'b0);
    #1;
    chk("s2_cnt5", 32'(count), 32'd5);
    for (int i = 1; i <= DEPTH; i++) begin
      #1;
      chk("s2_order", 32'(down_data), 32'(i));
      step("s2_drain", 1'b0, '0, 1'b1);
    end
    #1;
    chk("s2_empty", 32'(empty), 32'd1);

    // 3: continuous streaming through wrap
    for (int i = 0; i < 12; i++) begin
      step("s3_stream", 1'b1, 8'(i), 1'b1);
      #1;
      chk("s3_cnt_le1", 32'(count <= 1), 32'd1);
      chk("s3_data", 32'(down_data), 32'(i));
    end
    drain("s3");

    // 4: single pop at full, refill freed slot
    for (int i = 0; i < DEPTH; i++) step("s4_fill", 1'b1, 8'h40 + 8'(i), 1'b0);
    step("s4_pop", 1'b0, '0, 1'b1);
    #1;
    chk("s4_cnt4", 32'(count), 32'd4);
    chk("s4_upready", 32'(up_ready), 32'd1);
    step("s4_refill", 1'b1, 8'h4F, 1'b0);
    drain("s4");

    // 5: simultaneous push/pop at count 2
    step("s5_fill", 1'b1, 8'hA0, 1'b0);
    step("s5_fill", 1'b1, 8'hA1, 1'b0);
    step("s5_both", 1'b1, 8'hAA, 1'b1);
    #1;
    chk("s5_cnt2", 32'(count), 32'd2);
    chk("s5_head", 32'(down_data), 32'hA1);
    step("s5_pop", 1'b0, '0, 1'b1);
    #1;
    chk("s5_last", 32'(down_data), 32'hAA);
    drain("s5");

    // 6: asynchronous reset between edges
    for (int i = 0; i < 3; i++) step("s6_fill", 1'b1, 8'hC0 + 8'(i), 1'b0);
    up_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("s6_cnt0", 32'(count), 32'd0);
    chk("s6_dvalid", 32'(down_valid), 32'd0);
    chk("s6_upready", 32'(up_ready), 32'd1);
    #1;
    rst = 1'b0;
    model_q.delete();
    step("s6_push", 1'b1, 8'h5A, 1'b0);
    #1;
    chk("s6_dvalid1", 32'(down_valid), 32'd1);
    chk("s6_data", 32'(down_data), 32'h5A);
    drain("s6");

    // random traffic
    for (int i = 0; i < 400; i++)
      step("rnd", $urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50);
    drain("rnd");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
